// File: rtl/num_pkg.sv
// num_pkg: shared definitions for the num symbol stream.
//   SYM_*   : 2-bit symbol constants (SYM_IDLE is the detector's neutral symbol)
//   state_t : num_sender playback state
package num_pkg;

   localparam logic [1:0] SYM_IDLE = 2'b00;
   localparam logic [1:0] SYM_A    = 2'b01;
   localparam logic [1:0] SYM_B    = 2'b10;
   localparam logic [1:0] SYM_C    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/num_pat_buf.sv
// num_pat_buf: DEPTH x 2-bit pattern register file.
//   clk, rst_n : clock, async active-low reset (clears count only)
//   we, wdata  : append wdata at index count (caller guarantees !full)
//   clr        : empty the buffer
//   rd_idx     : asynchronous read address -> rdata
//   count,full : occupancy
module num_pat_buf #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1),
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [1:0]       wdata,
   input  logic             clr,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rdata,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   logic [1:0] mem [DEPTH];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (we) mem[count[IDX_W-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   count <= '0;
      else if (clr) count <= '0;
      else if (we)  count <= count + CNT_W'(1);
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign rdata = mem[rd_idx];

endmodule

// File: rtl/num_sender.sv
// num_sender: plays a loaded pattern of 2-bit symbols onto num.
//   clk, rst_n      : clock, async active-low reset
//   wr_en, wr_data  : append a symbol (IDLE only)
//   clear           : empty the pattern (IDLE only)
//   start           : begin playback, latching hold and rpt (IDLE only)
//   hold            : cycles per symbol minus 1
//   rpt             : extra repetitions of the whole pattern
//   abort           : stop playback at once, no done
//   num, valid      : transmitted symbol / symbol qualifier (registered)
//   busy, done, err : playback status, completion pulse, rejection pulse
//   count, full     : pattern occupancy
module num_sender
   import num_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int HOLD_W = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [1:0]        wr_data,
   input  logic              clear,
   input  logic              start,
   input  logic [HOLD_W-1:0] hold,
   input  logic [3:0]        rpt,
   input  logic              abort,
   output logic [1:0]        num,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d, hcnt_q, hcnt_d;
   logic [3:0]        rcnt_q, rcnt_d;
   logic [1:0]        rd_sym;
   logic              valid_d, done_d, err_d, busy_d;
   logic              buf_we, buf_clr, last_sym;

   num_pat_buf #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (buf_we),
      .wdata  (wr_data),
      .clr    (buf_clr),
      .rd_idx (idx_d),
      .rdata  (rd_sym),
      .count  (count),
      .full   (full)
   );

   assign last_sym = (CNT_W'(idx_q) == count - CNT_W'(1));

   // idx/hcnt/rcnt describe the symbol shown in the cycle they are registered
   // for, so the buffer is read at the next index to keep num registered.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      hcnt_d  = hcnt_q;
      rcnt_d  = rcnt_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      buf_we  = 1'b0;
      buf_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_d  = wr_en;
               hold_d = hold;
               hcnt_d = hold;
               rcnt_d = rpt;
               idx_d  = '0;
               if (count != '0) begin
                  state_d = ST_SEND;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
               end
            end else if (clear) begin
               buf_clr = 1'b1;
            end else if (wr_en) begin
               if (full) err_d  = 1'b1;
               else      buf_we = 1'b1;
            end
         end
         ST_SEND: begin
            err_d = wr_en | start;
            if (abort) begin
               state_d = ST_IDLE;
            end else if (hcnt_q != '0) begin
               hcnt_d  = hcnt_q - HOLD_W'(1);
               valid_d = 1'b1;
            end else if (!last_sym) begin
               idx_d   = idx_q + IDX_W'(1);
               hcnt_d  = hold_q;
               valid_d = 1'b1;
            end else if (rcnt_q != '0) begin
               rcnt_d  = rcnt_q - 4'd1;
               idx_d   = '0;
               hcnt_d  = hold_q;
               valid_d = 1'b1;
            end else begin
               state_d = ST_FIN;
               done_d  = 1'b1;
            end
         end
         ST_FIN: begin
            err_d   = wr_en | start;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         hcnt_q  <= '0;
         rcnt_q  <= '0;
         num     <= SYM_IDLE;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         hcnt_q  <= hcnt_d;
         rcnt_q  <= rcnt_d;
         num     <= valid_d ? rd_sym : SYM_IDLE;
         valid   <= valid_d;
         busy    <= busy_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

endmodule

// File: tb/tb_num_sender.sv
module tb_num_sender;
   import num_pkg::*;

   localparam int DEPTH  = 8;
   localparam int HOLD_W = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              wr_en = 1'b0, clear = 1'b0, start = 1'b0, abort = 1'b0;
   logic [1:0]        wr_data = '0;
   logic [HOLD_W-1:0] hold = '0;
   logic [3:0]        rpt = '0;
   logic [1:0]        num;
   logic              valid, busy, done, full, err;
   logic [CNT_W-1:0]  count;

   int checks = 0;
   int errors = 0;

   logic [1:0] pat[$];    // model of the pattern buffer
   logic [1:0] exp_q[$];  // expected symbols of one playback, one per cycle

   num_sender #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .clear(clear), .start(start), .hold(hold), .rpt(rpt), .abort(abort),
      .num(num), .valid(valid), .busy(busy), .done(done),
      .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void build_stream(input int h, input int r);
      exp_q.delete();
      for (int rr = 0; rr <= r; rr++)
         foreach (pat[i])
            for (int k = 0; k <= h; k++) exp_q.push_back(pat[i]);
   endfunction

   task automatic do_clear();
      clear = 1'b1; tick(); clear = 1'b0;
      pat.delete();
   endtask

   task automatic do_write(input logic [1:0] s);
      wr_en = 1'b1; wr_data = s; tick(); wr_en = 1'b0;
      if (pat.size() < DEPTH) pat.push_back(s);
   endtask

   task automatic load_random(input int n);
      do_clear();
      for (int i = 0; i < n; i++) do_write(2'($urandom_range(3, 0)));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({num, valid, busy, done, err} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs: got %b required 000000", {num, valid, busy, done, err});
      end
      checks++;
      if (count !== '0 || full !== 1'b0) begin
         errors++; $display("FAIL reset_count: got count=%0d full=%b required 0/0", count, full);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int n, cyc;
      do_clear();
      do_write(SYM_A); do_write(SYM_B); do_write(SYM_C);
      checks++;
      if (count !== CNT_W'(3)) begin
         errors++; $display("FAIL basic_count: got %0d required 3", count);
      end
      hold = '0; rpt = '0; build_stream(0, 0);
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (num !== exp_q[i] || valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL basic_sym%0d: got num=%b valid=%b busy=%b done=%b required num=%b 1/1/0",
                               i, num, valid, busy, done, exp_q[i]);
         end
         tick();
      end
      checks++;
      if (num !== SYM_IDLE || valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_done: got num=%b valid=%b done=%b busy=%b required 00/0/1/1", num, valid, done, busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL basic_idle: got busy=%b done=%b required 0/0", busy, done);
      end
      n = 0; cyc = 0;
   endtask

   // Playback with hold=2, rpt=1 plus randomized rounds; count valid cycles against the model.
   task automatic test_hold_rpt();
      int n, cyc, h, r;
      for (int it = 0; it < 7; it++) begin
         if (it == 0) begin
            do_clear(); do_write(SYM_A); do_write(SYM_B); do_write(SYM_C);
            h = 2; r = 1;
         end else begin
            load_random(int'($urandom_range(DEPTH, 1)));
            h = int'($urandom_range(3, 0)); r = int'($urandom_range(3, 0));
         end
         hold = HOLD_W'(h); rpt = 4'(r); build_stream(h, r);
         start = 1'b1; tick(); start = 1'b0;
         hold = '0; rpt = '0;  // latched at start, later changes must not matter
         n = 0; cyc = 0;
         while (done !== 1'b1 && cyc < 1000) begin
            if (valid === 1'b1) begin
               checks++;
               if (n >= exp_q.size() || num !== exp_q[n]) begin
                  errors++; $display("FAIL hold_rpt%0d_sym%0d: got %b required %b", it, n, num,
                                     (n < exp_q.size()) ? exp_q[n] : 2'bxx);
               end
               n++;
            end
            tick(); cyc++;
         end
         checks++;
         if (done !== 1'b1 || n !== exp_q.size() || cyc !== exp_q.size()) begin
            errors++; $display("FAIL hold_rpt%0d_len: got done=%b valid_cycles=%0d send_cycles=%0d required 1/%0d/%0d",
                               it, done, n, cyc, exp_q.size(), exp_q.size());
         end
         if (it == 0) begin
            checks++;
            if (n !== 18) begin
               errors++; $display("FAIL hold2_rpt1_len: got %0d required 18", n);
            end
         end
         tick();
      end
   endtask

   task automatic test_empty();
      do_clear();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1 || num !== SYM_IDLE) begin
         errors++; $display("FAIL empty_start: got done=%b valid=%b busy=%b num=%b required 1/0/1/00", done, valid, busy, num);
      end
      tick();
      checks++;
      if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL empty_after: got done=%b valid=%b busy=%b required 0/0/0", done, valid, busy);
      end
   endtask

   task automatic test_full();
      int n, cyc;
      do_clear();
      for (int i = 0; i < 9; i++) begin
         do_write(2'($urandom_range(3, 0)));
         checks++;
         if (err !== (i == 8)) begin
            errors++; $display("FAIL full_err_w%0d: got %b required %b", i, err, (i == 8));
         end
      end
      checks++;
      if (count !== CNT_W'(DEPTH) || full !== 1'b1) begin
         errors++; $display("FAIL full_count: got count=%0d full=%b required %0d/1", count, full, DEPTH);
      end
      hold = '0; rpt = '0; build_stream(0, 0);
      start = 1'b1; wr_en = 1'b1; wr_data = 2'b01; tick(); start = 1'b0; wr_en = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL start_wr_err: got %b required 1", err);
      end
      n = 0; cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         if (valid === 1'b1) begin
            checks++;
            if (n >= exp_q.size() || num !== exp_q[n]) begin
               errors++; $display("FAIL full_play_sym%0d: got %b", n, num);
            end
            n++;
         end
         tick(); cyc++;
      end
      checks++;
      if (done !== 1'b1 || n !== DEPTH) begin
         errors++; $display("FAIL full_play_len: got done=%b symbols=%0d required 1/%0d", done, n, DEPTH);
      end
      tick();
   endtask

   task automatic test_abort();
      int n, cyc;
      load_random(int'($urandom_range(6, 3)));
      hold = '0; rpt = '0; build_stream(0, 0);
      start = 1'b1; tick(); start = 1'b0;
      tick();  // second symbol cycle
      checks++;
      if (num !== pat[1] || valid !== 1'b1) begin
         errors++; $display("FAIL abort_sym1: got num=%b valid=%b required %b/1", num, valid, pat[1]);
      end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++;
      if (num !== SYM_IDLE || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL abort_stop: got num=%b valid=%b busy=%b done=%b required 00/0/0/0", num, valid, busy, done);
      end
      start = 1'b1; tick(); start = 1'b0;
      n = 0; cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         checks++;
         if (valid !== 1'b1 || n >= exp_q.size() || num !== exp_q[n]) begin
            errors++; $display("FAIL replay_sym%0d: got num=%b valid=%b", n, num, valid);
         end
         n++;
         tick(); cyc++;
      end
      checks++;
      if (done !== 1'b1 || n !== exp_q.size()) begin
         errors++; $display("FAIL replay_len: got done=%b symbols=%0d required 1/%0d", done, n, exp_q.size());
      end
      tick();
   endtask

   task automatic test_reject_during_send();
      int n, cyc;
      logic prev_inj;
      load_random(int'($urandom_range(6, 3)));
      hold = HOLD_W'(1); rpt = '0; build_stream(1, 0);
      start = 1'b1; tick(); start = 1'b0;
      n = 0; cyc = 0; prev_inj = 1'b0;
      while (done !== 1'b1 && cyc < 100) begin
         checks++;
         if (err !== prev_inj || valid !== 1'b1 || n >= exp_q.size() || num !== exp_q[n]) begin
            errors++; $display("FAIL reject_cyc%0d: got num=%b valid=%b err=%b required num=%b valid=1 err=%b",
                               cyc, num, valid, err, (n < exp_q.size()) ? exp_q[n] : 2'bxx, prev_inj);
         end
         n++;
         wr_en = (cyc == 1); start = (cyc == 3); clear = (cyc == 4);
         wr_data = 2'b11;
         prev_inj = wr_en | start;
         tick(); cyc++;
         wr_en = 1'b0; start = 1'b0; clear = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || n !== exp_q.size() || count !== CNT_W'(pat.size())) begin
         errors++; $display("FAIL reject_end: got done=%b symbols=%0d count=%0d required 1/%0d/%0d",
                            done, n, count, exp_q.size(), pat.size());
      end
      tick();
   endtask

   task automatic test_reset_mid_send();
      load_random(4);
      hold = HOLD_W'(2); rpt = 4'd1;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (num !== SYM_IDLE || valid !== 1'b0 || busy !== 1'b0 || count !== '0) begin
         errors++; $display("FAIL reset_mid_send: got num=%b valid=%b busy=%b count=%0d required 00/0/0/0", num, valid, busy, count);
      end
      pat.delete();
      @(negedge clk); rst_n = 1'b1;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (done !== 1'b1 || valid !== 1'b0) begin
         errors++; $display("FAIL reset_lost_pattern: got done=%b valid=%b required 1/0", done, valid);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_rpt();
      test_empty();
      test_full();
      test_abort();
      test_reject_during_send();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
